mux_nto1_scan: RTL and testbench

Parametrised N-channel, W-bit-wide registered multiplexer with a valid/ready output stage.
- Direct mode: the channel is chosen by `sel`.
- Scan mode: an internal pointer auto-sequences through all channels, holding each for DWELL accepted samples.
- Sits between multi-channel sensor/data sources and a single downstream consumer that may apply backpressure.

---
 rtl/mux_nto1_scan.sv | 107 ++++++++++
 tb/tb_mux_nto1_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_scan.sv
// N-channel registered multiplexer with valid/ready output stage.
// Direct mode selects by `sel`; scan mode walks all channels, DWELL accepted samples each.
module mux_nto1_scan #(
  parameter int unsigned N     = 16,
  parameter int unsigned W     = 8,
  parameter int unsigned DWELL = 1,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*W-1:0]    in_data,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wrap
);

  localparam int unsigned     DW      = $clog2(DWELL + 1);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);
  localparam logic [SELW:0]   N_EXT   = (SELW + 1)'(N);
  localparam logic [DW-1:0]   DLAST   = DW'(DWELL - 1);

  logic [W-1:0]    chan [N];
  logic [W-1:0]    data_q,  data_d;
  logic [SELW-1:0] ch_q,    ch_d;
  logic            valid_q, valid_d;
  logic            wrap_q,  wrap_d;
  logic [SELW-1:0] ptr_q,   ptr_d;
  logic [DW-1:0]   dcnt_q,  dcnt_d;
  logic            mode_q,  mode_d;

  logic            cap;
  logic            entry;
  logic [SELW-1:0] ptr_cur;
  logic [DW-1:0]   dcnt_cur;
  logic [SELW-1:0] sel_c;
  logic [SELW-1:0] ch_sel;

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      chan[k] = in_data[k*W +: W];
    end
  end

  always_comb begin
    cap      = en && (!valid_q || out_ready);
    // Scan entry zeroes the pointer on this same edge, so a coincident capture sees channel 0.
    entry    = mode && !mode_q;
    ptr_cur  = entry ? '0 : ptr_q;
    dcnt_cur = entry ? '0 : dcnt_q;
    sel_c    = ({1'b0, sel} >= N_EXT) ? LAST_CH : sel;
    ch_sel   = mode ? ptr_cur : sel_c;

    data_d   = data_q;
    ch_d     = ch_q;
    valid_d  = valid_q && !out_ready;
    wrap_d   = 1'b0;
    ptr_d    = ptr_cur;
    dcnt_d   = dcnt_cur;
    mode_d   = mode;

    if (cap) begin
      data_d  = chan[ch_sel];
      ch_d    = ch_sel;
      valid_d = 1'b1;
      if (mode) begin
        if (dcnt_cur == DLAST) begin
          dcnt_d = '0;
          ptr_d  = (ptr_cur == LAST_CH) ? '0 : ptr_cur + SELW'(1);
          wrap_d = (ptr_cur == LAST_CH);
        end else begin
          dcnt_d = dcnt_cur + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ptr_q   <= '0;
      dcnt_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
      mode_q  <= mode_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed bench for mux_nto1_scan: four configurations, scoreboard of captured samples.
module tb_mux_nto1_scan;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] chan [16];
  logic [7:0] sel;
  logic       mode, en, ready;
  int         act;

  logic [127:0] in16;
  logic [31:0]  in4;
  logic [39:0]  in5;

  always_comb begin
    for (int i = 0; i < 16; i++) in16[i*8 +: 8] = chan[i];
    for (int i = 0; i < 4; i++)  in4[i*8 +: 8]  = chan[i];
    for (int i = 0; i < 5; i++)  in5[i*8 +: 8]  = chan[i];
  end

  logic en0, en1, en2, en3;
  assign en0 = en && (act == 0);
  assign en1 = en && (act == 1);
  assign en2 = en && (act == 2);
  assign en3 = en && (act == 3);

  logic [7:0] d0, d1, d2, d3;
  logic [3:0] c0;
  logic [1:0] c1, c2;
  logic [2:0] c3;
  logic       v0, v1, v2, v3, w0, w1, w2, w3;

  mux_nto1_scan #(.N(16), .W(8), .DWELL(1)) u_n16 (
    .clk(clk), .rst_n(rst_n), .in_data(in16), .sel(sel[3:0]), .mode(mode), .en(en0),
    .out_data(d0), .out_ch(c0), .out_valid(v0), .out_ready(ready), .wrap(w0));
  mux_nto1_scan #(.N(4), .W(8), .DWELL(1)) u_n4d1 (
    .clk(clk), .rst_n(rst_n), .in_data(in4), .sel(sel[1:0]), .mode(mode), .en(en1),
    .out_data(d1), .out_ch(c1), .out_valid(v1), .out_ready(ready), .wrap(w1));
  mux_nto1_scan #(.N(4), .W(8), .DWELL(3)) u_n4d3 (
    .clk(clk), .rst_n(rst_n), .in_data(in4), .sel(sel[1:0]), .mode(mode), .en(en2),
    .out_data(d2), .out_ch(c2), .out_valid(v2), .out_ready(ready), .wrap(w2));
  mux_nto1_scan #(.N(5), .W(8), .DWELL(1)) u_n5 (
    .clk(clk), .rst_n(rst_n), .in_data(in5), .sel(sel[2:0]), .mode(mode), .en(en3),
    .out_data(d3), .out_ch(c3), .out_valid(v3), .out_ready(ready), .wrap(w3));

  logic [7:0] obs_data, obs_ch;
  logic       obs_valid, obs_wrap;
  always_comb begin
    obs_data = d0; obs_ch = {4'b0, c0}; obs_valid = v0; obs_wrap = w0;
    case (act)
      1: begin obs_data = d1; obs_ch = {6'b0, c1}; obs_valid = v1; obs_wrap = w1; end
      2: begin obs_data = d2; obs_ch = {6'b0, c2}; obs_valid = v2; obs_wrap = w2; end
      3: begin obs_data = d3; obs_ch = {5'b0, c3}; obs_valid = v3; obs_wrap = w3; end
      default: ;
    endcase
  end

  typedef struct { logic [7:0] d; logic [7:0] c; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int m_n, m_dwell, m_ptr, m_dcnt;
  bit m_modeq, m_valid, m_wrap;
  bit bp_chk, have_last;
  int last_ch;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_ptr = 0; m_dcnt = 0; m_modeq = 0; m_wrap = 0;
  endtask

  // Called with inputs settled, just before the rising edge.
  task automatic model_pre();
    bit cap, entry, wr;
    int p, d, c;
    if (m_valid && ready) begin
      if (bp_chk) begin
        if (have_last) chk("bp_order", obs_ch, (last_ch + 1) % m_n);
        last_ch   = obs_ch;
        have_last = 1;
      end
      if (q.size() > 0) void'(q.pop_front());
    end
    cap   = en && (!m_valid || ready);
    entry = mode && !m_modeq;
    p     = entry ? 0 : m_ptr;
    d     = entry ? 0 : m_dcnt;
    wr    = 0;
    if (cap) begin
      c = mode ? p : ((int'(sel) >= m_n) ? m_n - 1 : int'(sel));
      q.push_back('{chan[c], 8'(c)});
      if (mode) begin
        if (d == m_dwell - 1) begin
          wr = (p == m_n - 1);
          d  = 0;
          p  = (p == m_n - 1) ? 0 : p + 1;
        end else begin
          d++;
        end
      end
      m_valid = 1;
    end else if (ready) begin
      m_valid = 0;
    end
    m_ptr = p; m_dcnt = d; m_modeq = mode; m_wrap = wr;
  endtask

  task automatic cyc();
    model_pre();
    @(posedge clk);
    #1;
    chk("valid", obs_valid, m_valid);
    chk("wrap", obs_wrap, m_wrap);
    if (m_valid && q.size() > 0) begin
      chk("data", obs_data, q[0].d);
      chk("ch", obs_ch, q[0].c);
    end
  endtask

  task automatic start(input int a, input int n, input int dw);
    act = a; m_n = n; m_dwell = dw;
    en = 0; mode = 0; ready = 1; sel = 0;
    bp_chk = 0; have_last = 0; last_ch = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", obs_valid, 0);
    chk("rst_data", obs_data, 0);
    chk("rst_ch", obs_ch, 0);
    chk("rst_wrap", obs_wrap, 0);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; act = 0; sel = 0; mode = 0; en = 0; ready = 1;
    for (int k = 0; k < 16; k++) chan[k] = 8'(8'hA0 + k);

    start(0, 16, 1);
    en = 1;
    for (int s = 0; s < 16; s++) begin
      sel = 8'(s);
      cyc();
      chk("sweep_data", obs_data, 8'(8'hA0 + s));
      chk("sweep_ch", obs_ch, s);
    end

    chan[0] = 8'h11; chan[1] = 8'h22; chan[2] = 8'h33; chan[3] = 8'h44; chan[4] = 8'h55;

    start(1, 4, 1);
    mode = 1; en = 1;
    repeat (10) cyc();

    start(2, 4, 3);
    mode = 1; en = 1;
    cyc(); cyc();
    ready = 0;
    repeat (5) begin
      cyc();
      chk("stall_data", obs_data, 8'h11);
    end
    ready = 1;
    cyc();
    chk("release_data", obs_data, 8'h11);
    cyc();
    chk("next_data", obs_data, 8'h22);
    repeat (4) cyc();
    en = 0;
    cyc();
    chk("drain_data", obs_data, 8'h33);
    cyc();

    start(3, 5, 1);
    en = 1; sel = 8'd7;
    cyc();
    chk("np2_ch", obs_ch, 4);
    chk("np2_data", obs_data, 8'h55);
    cyc();
    mode = 1;
    cyc();
    chk("entry_ch", obs_ch, 0);
    chk("entry_data", obs_data, 8'h11);
    repeat (6) cyc();

    start(1, 4, 1);
    mode = 1; en = 1; bp_chk = 1;
    for (int i = 0; i < 16; i++) begin
      ready = (i % 2 == 0);
      cyc();
    end
    bp_chk = 0; ready = 1;

    start(1, 4, 1);
    mode = 1; en = 1;
    repeat (4) cyc();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", obs_valid, 0);
    chk("arst_data", obs_data, 0);
    chk("arst_wrap", obs_wrap, 0);
    model_reset();
    #1 rst_n = 1;
    cyc();
    chk("restart_ch", obs_ch, 0);
    chk("restart_data", obs_data, 8'h11);
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
